// File: rtl/jesd204b_pkg.sv
// Shared types and control-octet constants for the JESD204B receive lane synchroniser.
package jesd204b_pkg;

  typedef enum logic [1:0] {
    SYNC_REQ = 2'd0,
    CGS_DONE = 2'd1,
    ILAS     = 2'd2,
    DATA     = 2'd3
  } lane_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  // A full code-group-sync word: four K28.5 characters, all flagged as K.
  function automatic logic is_cgs_word(input logic [31:0] data, input logic [3:0] charisk);
    return (charisk == 4'hF) && (data == {4{K28_5}});
  endfunction

endpackage

// File: rtl/jesd204b_ilas_counter.sv
// ILAS octet/multiframe position tracker; reports multiframe wrap and head-of-multiframe for the current word.
module jesd204b_ilas_counter #(
  parameter int unsigned OCT_PER_MF = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       advance,
  output logic [1:0] mf_cur,
  output logic       wrap,
  output logic       mf_head
);

  localparam int unsigned OW = $clog2(OCT_PER_MF + 1);

  logic [OW-1:0] oct_cnt;
  logic [OW-1:0] oct_base;
  logic [OW-1:0] oct_sum;
  logic [1:0]    mf_cnt;

  // The start word is counted from position zero so the flags are valid for it too.
  always_comb begin
    oct_base = start ? '0 : oct_cnt;
    oct_sum  = oct_base + OW'(4);
    mf_cur   = start ? '0 : mf_cnt;
    wrap     = (oct_sum == OW'(OCT_PER_MF));
    mf_head  = (oct_base == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oct_cnt <= '0;
      mf_cnt  <= '0;
    end else if (start || advance) begin
      oct_cnt <= wrap ? '0 : oct_sum;
      mf_cnt  <= wrap ? mf_cur + 2'd1 : mf_cur;
    end else begin
      oct_cnt <= '0;
      mf_cnt  <= '0;
    end
  end

endmodule

// File: rtl/jesd204b_rx_lane_sync.sv
// JESD204B receive lane synchroniser: CGS, ILAS tracking, DATA gating and error-driven resync.
// Optional ILAS content checking is enabled by defining JESD_RX_ILAS_CHECK_EN.
module jesd204b_rx_lane_sync
  import jesd204b_pkg::*;
#(
  parameter int unsigned FRAME_SIZE = 1,
  parameter int unsigned FMLC_NUM   = 8,
  parameter int unsigned CGS_CYCLES = 4,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_charisk,
  input  logic [3:0]  i_rx_disperr,
  input  logic [3:0]  i_rx_notintable,
  output logic        o_nsync,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  output logic [1:0]  o_state,
  output logic        o_ilas_err
);

  localparam int unsigned CW = $clog2(CGS_CYCLES + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  lane_state_t   state, next;
  logic [CW-1:0] cgs_cnt, cgs_next;
  logic [EW-1:0] err_cnt, err_next;
  logic          nsync;
  logic [31:0]   data;
  logic          valid;

  logic          cgs_word;
  logic          r_word;
  logic          errored;
  logic          start;
  logic          advance;
  logic [1:0]    mf_cur;
  logic          wrap;
  logic          mf_head;

  jesd204b_ilas_counter #(
    .OCT_PER_MF(FRAME_SIZE * FMLC_NUM)
  ) u_ilas_counter (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (start),
    .advance(advance),
    .mf_cur (mf_cur),
    .wrap   (wrap),
    .mf_head(mf_head)
  );

  always_comb begin
    cgs_word = is_cgs_word(i_rx_data, i_rx_charisk);
    r_word   = (i_rx_data[7:0] == K28_0) && i_rx_charisk[0];
    errored  = |{i_rx_disperr, i_rx_notintable};
  end

  always_comb begin
    next     = state;
    cgs_next = cgs_cnt;
    err_next = err_cnt;
    start    = 1'b0;
    advance  = 1'b0;

    case (state)
      SYNC_REQ: begin
        if (cgs_word) begin
          if (cgs_cnt == CW'(CGS_CYCLES - 1)) begin
            next     = CGS_DONE;
            cgs_next = '0;
          end else begin
            cgs_next = cgs_cnt + CW'(1);
          end
        end else begin
          cgs_next = '0;
        end
      end
      CGS_DONE: begin
        if (!cgs_word) begin
          if (r_word) begin
            next  = ILAS;
            start = 1'b1;
          end else begin
            next = SYNC_REQ;
          end
        end
      end
      ILAS: begin
        if (wrap && (mf_cur == 2'd3)) next = DATA;
      end
      DATA: ;
      default: next = SYNC_REQ;
    endcase

    // Error-limit resync overrides any other transition decided above.
    if ((state == ILAS) || (state == DATA)) begin
      if (errored) begin
        if (err_cnt == EW'(ERR_LIMIT - 1)) next = SYNC_REQ;
        else err_next = err_cnt + EW'(1);
      end else begin
        err_next = '0;
      end
    end

    if (next == SYNC_REQ && state != SYNC_REQ) begin
      err_next = '0;
      cgs_next = '0;
    end

    advance = (state == ILAS) && (next != SYNC_REQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= SYNC_REQ;
      cgs_cnt <= '0;
      err_cnt <= '0;
      nsync   <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= next;
      cgs_cnt <= cgs_next;
      err_cnt <= err_next;
      nsync   <= (next != SYNC_REQ);
      if (state == DATA && next == DATA) begin
        data  <= i_rx_data;
        valid <= 1'b1;
      end else begin
        data  <= '0;
        valid <= 1'b0;
      end
    end
  end

  assign o_nsync      = nsync;
  assign o_data       = data;
  assign o_data_valid = valid;
  assign o_state      = state;

`ifdef JESD_RX_ILAS_CHECK_EN
  logic ilas_err;
  logic ilas_bad;

  // Multiframe tail must be K28.3; the second multiframe carries K28.4 right after its /R/.
  always_comb begin
    ilas_bad = 1'b0;
    if (start || advance) begin
      if (wrap && !((i_rx_data[31:24] == K28_3) && i_rx_charisk[3])) ilas_bad = 1'b1;
      if (mf_head && (mf_cur == 2'd1) &&
          !((i_rx_data[15:8] == K28_4) && i_rx_charisk[1])) ilas_bad = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ilas_err <= 1'b0;
    end else if (next == SYNC_REQ) begin
      ilas_err <= 1'b0;
    end else if (ilas_bad) begin
      ilas_err <= 1'b1;
    end
  end

  assign o_ilas_err = ilas_err;
`else
  logic unused_mf_head;
  assign unused_mf_head = mf_head;
  assign o_ilas_err     = 1'b0;
`endif

endmodule

// File: tb/tb_jesd204b_rx_lane_sync.sv
// Directed scoreboard bench for jesd204b_rx_lane_sync (defaults F=1, K=8, CGS=4, ERR_LIMIT=3).
module tb_jesd204b_rx_lane_sync;

  logic        clk;
  logic        rst_n;
  logic [31:0] rx_data;
  logic [3:0]  rx_charisk;
  logic [3:0]  rx_disperr;
  logic [3:0]  rx_notintable;
  logic        nsync;
  logic [31:0] data;
  logic        data_valid;
  logic [1:0]  state;
  logic        ilas_err;

`ifdef JESD_RX_ILAS_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  st;
    logic        ns;
    logic        vl;
    logic [31:0] dt;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned step_no = 0;

  jesd204b_rx_lane_sync #(
    .FRAME_SIZE(1),
    .FMLC_NUM  (8),
    .CGS_CYCLES(4),
    .ERR_LIMIT (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_charisk   (rx_charisk),
    .i_rx_disperr   (rx_disperr),
    .i_rx_notintable(rx_notintable),
    .o_nsync        (nsync),
    .o_data         (data),
    .o_data_valid   (data_valid),
    .o_state        (state),
    .o_ilas_err     (ilas_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s step %0d: observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_nsync", {31'd0, nsync}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_ilas_err", {31'd0, ilas_err}, 32'd0);
  endtask

  task automatic word(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                      input logic [1:0] st, input logic ns, input logic vl, input logic [31:0] dt);
    exp_t e;
    rx_data       = d;
    rx_charisk    = k;
    rx_disperr    = de;
    rx_notintable = 4'h0;
    sb.push_back('{st: st, ns: ns, vl: vl, dt: dt});
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    chk("state", {30'd0, state}, {30'd0, e.st});
    chk("nsync", {31'd0, nsync}, {31'd0, e.ns});
    chk("valid", {31'd0, data_valid}, {31'd0, e.vl});
    chk("data", data, e.dt);
  endtask

  task automatic kword(input logic [1:0] st, input logic ns);
    word(32'hBCBCBCBC, 4'hF, 4'h0, st, ns, 1'b0, 32'h0);
  endtask

  task automatic cgs_to_done();
    for (int unsigned i = 0; i < 3; i++) kword(2'd0, 1'b0);
    kword(2'd1, 1'b1);
  endtask

  // Full 4-multiframe ILAS, first word being /R/; optionally corrupts multiframe 2's K28.3.
  task automatic ilas_seq(input logic bad);
    logic [31:0] w0, w1;
    logic [3:0]  k0, k1;
    for (int unsigned m = 0; m < 4; m++) begin
      w0 = (m == 1) ? 32'h02019C1C : 32'h0302011C;
      k0 = (m == 1) ? 4'b0011 : 4'b0001;
      w1 = (bad && m == 2) ? 32'h00060504 : 32'h7C060504;
      k1 = (bad && m == 2) ? 4'b0000 : 4'b1000;
      word(w0, k0, 4'h0, 2'd2, 1'b1, 1'b0, 32'h0);
      word(w1, k1, 4'h0, (m == 3) ? 2'd3 : 2'd2, 1'b1, 1'b0, 32'h0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    rx_data       = '0;
    rx_charisk    = '0;
    rx_disperr    = '0;
    rx_notintable = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    #2 rst_n = 1'b1;

    // Plain CGS: nsync rises with CGS_DONE, one cycle after the 4th comma word.
    cgs_to_done();
    kword(2'd1, 1'b1);
    word(32'h00000000, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 32'h0);

    // An interrupted run must restart the count.
    for (int unsigned i = 0; i < 3; i++) kword(2'd0, 1'b0);
    word(32'h00000000, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    cgs_to_done();

    // ILAS then first user word appears one cycle later.
    ilas_seq(1'b0);
    chk("ilas_err_clean", {31'd0, ilas_err}, 32'd0);
    word(32'h11223344, 4'h0, 4'h0, 2'd3, 1'b1, 1'b1, 32'h11223344);
    word(32'hAABBCCDD, 4'h0, 4'h0, 2'd3, 1'b1, 1'b1, 32'hAABBCCDD);

    // Two errors then a clean word keep DATA; three in a row force resync.
    word(32'h55555555, 4'h0, 4'h1, 2'd3, 1'b1, 1'b1, 32'h55555555);
    word(32'h66666666, 4'h0, 4'h1, 2'd3, 1'b1, 1'b1, 32'h66666666);
    word(32'h77777777, 4'h0, 4'h0, 2'd3, 1'b1, 1'b1, 32'h77777777);
    word(32'h88888888, 4'h0, 4'h1, 2'd3, 1'b1, 1'b1, 32'h88888888);
    word(32'h99999999, 4'h0, 4'h1, 2'd3, 1'b1, 1'b1, 32'h99999999);
    word(32'hAAAAAAAA, 4'h0, 4'h1, 2'd0, 1'b0, 1'b0, 32'h0);

    // Corrupted multiframe tail: flagged only when content checks are built in.
    cgs_to_done();
    ilas_seq(1'b1);
    chk("ilas_err_bad", {31'd0, ilas_err}, {31'd0, CHK_EN});
    word(32'h12345678, 4'h0, 4'h0, 2'd3, 1'b1, 1'b1, 32'h12345678);
    chk("ilas_err_sticky", {31'd0, ilas_err}, {31'd0, CHK_EN});
    word(32'hDEAD0001, 4'h0, 4'h2, 2'd3, 1'b1, 1'b1, 32'hDEAD0001);
    word(32'hDEAD0002, 4'h0, 4'h2, 2'd3, 1'b1, 1'b1, 32'hDEAD0002);
    word(32'hDEAD0003, 4'h0, 4'h2, 2'd0, 1'b0, 1'b0, 32'h0);
    chk("ilas_err_cleared", {31'd0, ilas_err}, 32'd0);

    // Reset pulsed mid-ILAS: outputs drop asynchronously, CGS restarts.
    cgs_to_done();
    word(32'h0302011C, 4'b0001, 4'h0, 2'd2, 1'b1, 1'b0, 32'h0);
    word(32'h7C060504, 4'b1000, 4'h0, 2'd2, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    #2 rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) kword(2'd0, 1'b0);

    // Reset with a partial comma count must not keep stale progress.
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    #2 rst_n = 1'b1;
    cgs_to_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: observed=no finish expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
